rvvi_frame_reflector: RTL and testbench

//  Host-side RVVI frame reflector for the acev Ethernet loop-back bench; synthesizable, so it can also sit on FPGA.

---
 rtl/rvvi_frame_reflector.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_rvvi_frame_reflector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_frame_reflector.sv
// -----------------------------------------------------------------------------
// rvvi_frame_reflector
//
// Purpose:
//   Host-side RVVI frame reflector for the acev Ethernet loop-back bench.
//   Each AXI-stream frame from the MAC rx FIFO is captured into a small word
//   memory. The block then replies with a shortened frame made of:
//     - the header words,
//     - a kept window of rx words,
//     - a pseudo-random 32-bit host-load word.
//   Every DROP_PERIOD-th complete frame gets no reply, so that the acev
//   retry and timeout paths are exercised.
//   Frames that end early are discarded and counted. Beats beyond RX_WORDS
//   are accepted and thrown away.
//
// Ports:
//   i_clk                single clock
//   i_reset              asynchronous active-high reset
//   i_rx_tdata/tvalid/tlast, o_rx_tready   rx AXI-stream slave
//   o_tx_tdata/tkeep/tvalid/tlast, i_tx_tready   reply AXI-stream master
//   o_rx_frame_count     complete frames captured
//   o_tx_frame_count     replies fully sent
//   o_drop_count         replies suppressed
//   o_short_count        frames discarded because tlast came before RX_WORDS beats
//   All status counters saturate at all ones.
// -----------------------------------------------------------------------------
module rvvi_frame_reflector #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          RX_WORDS    = 12,
   parameter int          HDR_WORDS   = 3,
   parameter int          KEEP_IDX    = 8,
   parameter int          KEEP_WORDS  = 3,
   parameter int          DROP_PERIOD = 10,
   parameter logic [31:0] LFSR_SEED   = 32'h0000_0001,
   parameter int          CNT_WIDTH   = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [DATA_WIDTH-1:0]   i_rx_tdata,
   input  logic                    i_rx_tvalid,
   output logic                    o_rx_tready,
   input  logic                    i_rx_tlast,
   output logic [DATA_WIDTH-1:0]   o_tx_tdata,
   output logic [DATA_WIDTH/8-1:0] o_tx_tkeep,
   output logic                    o_tx_tvalid,
   input  logic                    i_tx_tready,
   output logic                    o_tx_tlast,
   output logic [CNT_WIDTH-1:0]    o_rx_frame_count,
   output logic [CNT_WIDTH-1:0]    o_tx_frame_count,
   output logic [CNT_WIDTH-1:0]    o_drop_count,
   output logic [CNT_WIDTH-1:0]    o_short_count
);

   localparam int TX_WORDS = HDR_WORDS + KEEP_WORDS + 1;
   localparam int MW       = (RX_WORDS > 1) ? $clog2(RX_WORDS) : 1;
   localparam int KW       = $clog2(TX_WORDS + 1);
   localparam int SW       = $clog2(DROP_PERIOD + 2);

   localparam logic [MW-1:0] LAST_IDX   = MW'(RX_WORDS - 1);
   localparam logic [KW-1:0] LAST_K     = KW'(TX_WORDS - 1);
   localparam logic [KW-1:0] HDR_K      = KW'(HDR_WORDS);
   localparam logic [KW-1:0] KEEP_END_K = KW'(HDR_WORDS + KEEP_WORDS);
   localparam logic [SW-1:0] DROP_S     = SW'(DROP_PERIOD);
   // Galois taps for x^32+x^22+x^2+x+1 (right-shifting form)
   localparam logic [31:0]   LFSR_TAPS  = 32'h8020_0003;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_SEND    = 2'd3
   } state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : (v + CNT_WIDTH'(1));
   endfunction

   state_t                  r_state;
   state_t                  w_state_next;
   logic [MW-1:0]           r_idx;
   logic [DATA_WIDTH-1:0]   r_mem [RX_WORDS];
   logic [SW-1:0]           r_seq;
   logic                    r_drop_pend;
   logic                    r_drop;
   logic [31:0]             r_lfsr;
   logic [31:0]             r_load;
   logic [KW-1:0]           r_tx_k;
   logic [DATA_WIDTH-1:0]   r_tx_tdata;
   logic                    r_tx_tvalid;
   logic                    r_tx_tlast;
   logic                    r_rx_tready;
   logic [CNT_WIDTH-1:0]    r_rx_cnt;
   logic [CNT_WIDTH-1:0]    r_tx_cnt;
   logic [CNT_WIDTH-1:0]    r_drop_cnt;
   logic [CNT_WIDTH-1:0]    r_short_cnt;

   logic                    w_rx_beat;
   logic                    w_tx_hs;
   logic                    w_mem_we;
   logic [MW-1:0]           w_wr_addr;
   logic                    w_frame_done;
   logic                    w_short;
   logic                    w_enter_send;
   logic                    w_send_done;
   logic                    w_drop_done;
   logic [SW-1:0]           w_seq_inc;
   logic                    w_hit;
   logic                    w_drop_now;
   logic [31:0]             w_lfsr_next;
   logic [KW-1:0]           w_word_k;
   logic [7:0]              w_keep_off;
   logic [MW-1:0]           w_src_idx;
   logic                    w_src_is_load;
   logic                    w_bypass;
   logic [31:0]             w_load_src;
   logic [DATA_WIDTH-1:0]   w_word;

   assign w_rx_beat   = i_rx_tvalid & r_rx_tready;
   assign w_tx_hs     = r_tx_tvalid & i_tx_tready;
   assign w_lfsr_next = lfsr_step(r_lfsr);
   assign w_wr_addr   = (r_state == ST_IDLE) ? '0 : r_idx;

   // The drop decision belongs to the frame that pushes the sequence onto DROP_PERIOD
   assign w_seq_inc  = r_seq + SW'(1);
   assign w_hit      = (DROP_PERIOD != 0) && (w_seq_inc == DROP_S);
   assign w_drop_now = w_frame_done ? w_hit : r_drop_pend;

   // Next-state logic and per-cycle event strobes
   always_comb begin
      w_state_next = r_state;
      w_mem_we     = 1'b0;
      w_frame_done = 1'b0;
      w_short      = 1'b0;
      w_enter_send = 1'b0;
      w_send_done  = 1'b0;
      w_drop_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rx_beat) begin
               w_mem_we = 1'b1;
               if (i_rx_tlast) begin
                  w_short      = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_state_next = ST_CAPTURE;
               end
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            if (w_rx_beat) begin
               w_mem_we = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_frame_done = 1'b1;
                  w_enter_send = i_rx_tlast;
                  w_state_next = i_rx_tlast ? ST_SEND : ST_DRAIN;
               end else if (i_rx_tlast) begin
                  w_short      = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_state_next = ST_CAPTURE;
               end
            end else begin
               w_state_next = ST_CAPTURE;
            end
         end
         ST_DRAIN: begin
            if (w_rx_beat && i_rx_tlast) begin
               w_enter_send = 1'b1;
               w_state_next = ST_SEND;
            end else begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_SEND: begin
            if (r_drop) begin
               w_drop_done  = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_tx_hs && r_tx_tlast) begin
               w_send_done  = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_SEND;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Reply word selection: header copy, kept window, or load word.
   // On SEND entry the last rx beat is still being written, so it is forwarded directly.
   always_comb begin
      w_word_k      = w_enter_send ? '0 : (r_tx_k + KW'(1));
      w_keep_off    = 8'(KEEP_IDX) + 8'(w_word_k) - 8'(HDR_WORDS);
      w_src_idx     = '0;
      w_src_is_load = 1'b0;
      if (w_word_k < HDR_K) begin
         w_src_idx = MW'(w_word_k);
      end else if (w_word_k < KEEP_END_K) begin
         w_src_idx = MW'(w_keep_off);
      end else begin
         w_src_is_load = 1'b1;
      end
      w_bypass   = w_enter_send && (r_state == ST_CAPTURE) && (w_src_idx == LAST_IDX);
      w_load_src = w_enter_send ? w_lfsr_next : r_load;
      if (w_src_is_load) begin
         w_word = DATA_WIDTH'(w_load_src);
      end else if (w_bypass) begin
         w_word = i_rx_tdata;
      end else begin
         w_word = r_mem[w_src_idx];
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // rx beat index within the current frame
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_idx <= '0;
      end else if (w_rx_beat) begin
         case (r_state)
            ST_IDLE:    r_idx <= MW'(1);
            ST_CAPTURE: r_idx <= ((r_idx == LAST_IDX) || i_rx_tlast) ? '0 : (r_idx + MW'(1));
            default:    r_idx <= r_idx;
         endcase
      end
   end

   // Frame word memory; only the first RX_WORDS beats of a frame are stored
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < RX_WORDS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_mem_we) begin
         r_mem[w_wr_addr] <= i_rx_tdata;
      end
   end

   // Complete-frame sequence for periodic drops; short frames never touch it
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_seq       <= '0;
         r_drop_pend <= 1'b0;
      end else if (w_frame_done) begin
         r_seq       <= w_hit ? '0 : w_seq_inc;
         r_drop_pend <= w_hit;
      end
   end

   // Free-running load LFSR
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= w_lfsr_next;
      end
   end

   // Reply output registers; data and tlast only move on a handshake
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tx_k      <= '0;
         r_tx_tdata  <= '0;
         r_tx_tvalid <= 1'b0;
         r_tx_tlast  <= 1'b0;
         r_load      <= LFSR_SEED;
         r_drop      <= 1'b0;
      end else if (w_enter_send) begin
         r_drop      <= w_drop_now;
         r_tx_k      <= '0;
         r_load      <= w_lfsr_next;
         r_tx_tdata  <= w_word;
         r_tx_tvalid <= ~w_drop_now;
         r_tx_tlast  <= ~w_drop_now & (TX_WORDS == 1);
      end else if ((r_state == ST_SEND) && w_tx_hs) begin
         if (r_tx_tlast) begin
            r_tx_tvalid <= 1'b0;
            r_tx_tlast  <= 1'b0;
         end else begin
            r_tx_k      <= w_word_k;
            r_tx_tdata  <= w_word;
            r_tx_tlast  <= (w_word_k == LAST_K);
         end
      end
   end

   // rx backpressure: ready everywhere except SEND
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rx_tready <= 1'b1;
      end else begin
         r_rx_tready <= (w_state_next != ST_SEND);
      end
   end

   // Saturating status counters, each driven by its own event
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rx_cnt    <= '0;
         r_tx_cnt    <= '0;
         r_drop_cnt  <= '0;
         r_short_cnt <= '0;
      end else begin
         if (w_frame_done) r_rx_cnt    <= sat_inc(r_rx_cnt);
         if (w_send_done)  r_tx_cnt    <= sat_inc(r_tx_cnt);
         if (w_drop_done)  r_drop_cnt  <= sat_inc(r_drop_cnt);
         if (w_short)      r_short_cnt <= sat_inc(r_short_cnt);
      end
   end

   assign o_rx_tready      = r_rx_tready;
   assign o_tx_tdata       = r_tx_tdata;
   assign o_tx_tkeep       = '1;
   assign o_tx_tvalid      = r_tx_tvalid;
   assign o_tx_tlast       = r_tx_tlast;
   assign o_rx_frame_count = r_rx_cnt;
   assign o_tx_frame_count = r_tx_cnt;
   assign o_drop_count     = r_drop_cnt;
   assign o_short_count    = r_short_cnt;

endmodule

// File: tb/tb_rvvi_frame_reflector.sv
`timescale 1ns/1ps
// Directed-plus-random bench for rvvi_frame_reflector with a frame-level reference model.
module tb_rvvi_frame_reflector;

   localparam int          DW   = 32;
   localparam int          RXW  = 12;
   localparam int          HDR  = 3;
   localparam int          KIDX = 8;
   localparam int          KPW  = 3;
   localparam int          DROP = 10;
   localparam int          CW   = 16;
   localparam int          TXW  = HDR + KPW + 1;
   localparam logic [31:0] SEED = 32'h0000_0001;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] rx_tdata = '0;
   logic          rx_tvalid = 1'b0;
   logic          rx_tready;
   logic          rx_tlast = 1'b0;
   logic [DW-1:0] tx_tdata;
   logic [DW/8-1:0] tx_tkeep;
   logic          tx_tvalid;
   logic          tx_tready = 1'b0;
   logic          tx_tlast;
   logic [CW-1:0] rx_cnt, tx_cnt, drop_cnt, short_cnt;

   always #5 clk = ~clk;

   rvvi_frame_reflector #(
      .DATA_WIDTH(DW), .RX_WORDS(RXW), .HDR_WORDS(HDR), .KEEP_IDX(KIDX),
      .KEEP_WORDS(KPW), .DROP_PERIOD(DROP), .LFSR_SEED(SEED), .CNT_WIDTH(CW)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .i_rx_tdata(rx_tdata), .i_rx_tvalid(rx_tvalid), .o_rx_tready(rx_tready), .i_rx_tlast(rx_tlast),
      .o_tx_tdata(tx_tdata), .o_tx_tkeep(tx_tkeep), .o_tx_tvalid(tx_tvalid),
      .i_tx_tready(tx_tready), .o_tx_tlast(tx_tlast),
      .o_rx_frame_count(rx_cnt), .o_tx_frame_count(tx_cnt),
      .o_drop_count(drop_cnt), .o_short_count(short_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Clock edges seen since reset release: the LFSR has stepped this many times.
   int cyc;
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Frame-level model state
   int          m_rx = 0, m_tx = 0, m_drop = 0, m_short = 0;
   int          frames_done = 0;
   logic [31:0] cur [32];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_after(input int n);
      logic [31:0] s;
      s = SEED;
      for (int i = 0; i < n; i++) begin
         s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
      end
      return s;
   endfunction

   task automatic chk_counts();
      chk("rx_frame_count", rx_cnt, m_rx);
      chk("tx_frame_count", tx_cnt, m_tx);
      chk("drop_count", drop_cnt, m_drop);
      chk("short_count", short_cnt, m_short);
   endtask

   task automatic drive_frame(input int nb, input bit rnd, input int gap_pct);
      for (int i = 0; i < nb; i++) begin
         cur[i] = rnd ? $urandom : (32'h0000_0100 + i);
         if (int'($urandom_range(0, 99)) < gap_pct) begin
            rx_tvalid = 1'b0;
            tick();
         end
         rx_tdata  = cur[i];
         rx_tvalid = 1'b1;
         rx_tlast  = (i == nb - 1);
         chk("rx_tready_beat", rx_tready, 1);
         tick();
      end
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      rx_tdata  = '0;
   endtask

   task automatic check_short();
      m_short++;
      for (int i = 0; i < 2; i++) begin
         chk("short_no_tvalid", tx_tvalid, 0);
         chk("short_rx_tready", rx_tready, 1);
         tick();
      end
      chk_counts();
   endtask

   // Called right after the frame-completing beat; checks the reply (or drop) beat by beat.
   task automatic check_reply(input int duty, input int abort_k);
      logic [31:0] exp_w [TXW];
      logic [31:0] load;
      int k, n;
      frames_done++;
      m_rx++;
      if (frames_done % DROP == 0) begin
         chk("drop_tvalid_entry", tx_tvalid, 0);
         chk("drop_rx_tready_entry", rx_tready, 0);
         tick();
         chk("drop_tvalid_after", tx_tvalid, 0);
         chk("drop_rx_tready_after", rx_tready, 1);
         m_drop++;
      end else begin
         load = lfsr_after(cyc);
         for (int j = 0; j < TXW; j++) begin
            if (j < HDR)            exp_w[j] = cur[j];
            else if (j < HDR + KPW) exp_w[j] = cur[KIDX + j - HDR];
            else                    exp_w[j] = load;
         end
         k = 0;
         n = 0;
         while (k < TXW && n < 200) begin
            tx_tready = (int'($urandom_range(0, 99)) < duty);
            chk("tx_tvalid", tx_tvalid, 1);
            chk("tx_tdata", tx_tdata, exp_w[k]);
            chk("tx_tlast", tx_tlast, (k == TXW - 1));
            chk("tx_tkeep", tx_tkeep, 4'hF);
            chk("rx_tready_send", rx_tready, 0);
            if (k == abort_k) begin
               reset = 1'b1;
               #1;
               m_rx = 0; m_tx = 0; m_drop = 0; m_short = 0;
               frames_done = 0;
               chk("abort_tvalid", tx_tvalid, 0);
               chk("abort_tlast", tx_tlast, 0);
               chk_counts();
               tx_tready = 1'b0;
               tick();
               reset = 1'b0;
               tick();
               chk("abort_rx_tready", rx_tready, 1);
               return;
            end
            if (tx_tready) k++;
            tick();
            n++;
         end
         chk("reply_complete", k, TXW);
         tx_tready = 1'b0;
         chk("tx_idle_tvalid", tx_tvalid, 0);
         chk("tx_idle_rx_tready", rx_tready, 1);
         m_tx++;
      end
      chk_counts();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tvalid", tx_tvalid, 0);
      chk("reset_tlast", tx_tlast, 0);
      chk("reset_tkeep", tx_tkeep, 4'hF);
      chk_counts();
      reset = 1'b0;
      tick();
      chk("release_rx_tready", rx_tready, 1);

      // Frame 1: incrementing words, tx always ready
      drive_frame(12, 1'b0, 0);
      check_reply(100, -1);

      // Frames 2..25 back to back; 10 and 20 are dropped
      for (int f = 2; f <= 25; f++) begin
         drive_frame(12, 1'b1, 20);
         check_reply((f % 3 == 0) ? 30 : 100, -1);
      end
      chk("rx_count_25", rx_cnt, 25);
      chk("tx_count_23", tx_cnt, 23);
      chk("drop_count_2", drop_cnt, 2);

      // Short frames: 5 beats, single beat, one beat shy of full
      drive_frame(5, 1'b1, 0);
      check_short();
      drive_frame(1, 1'b1, 0);
      check_short();
      drive_frame(11, 1'b1, 0);
      check_short();
      chk("short_count_3", short_cnt, 3);

      // Normal frame after short ones, then an over-long frame
      drive_frame(12, 1'b1, 0);
      check_reply(100, -1);
      drive_frame(16, 1'b1, 0);
      check_reply(100, -1);

      // Stalled reply with rx gaps
      drive_frame(12, 1'b1, 30);
      check_reply(30, -1);

      // Reset during reply word 4, then a fresh frame with load word from the seed
      drive_frame(12, 1'b1, 0);
      check_reply(100, 4);
      drive_frame(12, 1'b0, 0);
      check_reply(100, -1);
      chk("post_reset_rx_count", rx_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
